// File: rtl/fft_stage_sequencer_if.sv
// Host/datapath bundle for the FFT stage sequencer: host start/abort/ack in,
// butterfly control (count, count_reg, flag), stage select/strobes and done out.
interface fft_stage_sequencer_if #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 3
);
    logic                  start;
    logic                  abort;
    logic                  ack;
    logic                  busy;
    logic                  load_en;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_reg;
    logic                  flag;
    logic [2:0]            stage_sel;
    logic [NUM_STAGES-1:0] stage_en;
    logic                  done;

    modport master (
        output start, abort, ack,
        input  busy, load_en, count, count_reg, flag, stage_sel, stage_en, done
    );

    modport slave (
        input  start, abort, ack,
        output busy, load_en, count, count_reg, flag, stage_sel, stage_en, done
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Purpose: sequences LOAD -> (MAC x MAC_CYCLES, WB) per stage -> DONE for a radix-2 FFT.
// Latency: load_en 1 cycle after start, done 2+NUM_STAGES*(MAC_CYCLES+1) cycles after start.
// Backpressure: start ignored while busy; done held until ack; abort cancels at once.
module fft_stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int MAC_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic                  clk_MAC,
    input  logic                  rst,
    fft_stage_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(MAC_CYCLES - 1);
    localparam logic [2:0]       LAST_STAGE = 3'(NUM_STAGES - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      count_reg_q, count_reg_d;
    logic [2:0]            stage_q, stage_d;
    logic                  busy_q, busy_d;
    logic                  load_en_q, load_en_d;
    logic                  flag_q, flag_d;
    logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d     = state_q;
        count_d     = '0;
        stage_d     = stage_q;
        count_reg_d = count_q;

        case (state_q)
            S_IDLE: begin
                stage_d = '0;
                if (bus.start && !bus.abort) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                stage_d = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (count_q == LAST_CNT) begin
                    state_d = S_WB;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            S_WB: begin
                if (stage_q == LAST_STAGE) begin
                    state_d = S_DONE;
                end else begin
                    stage_d = stage_q + 3'd1;
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                if (bus.ack) begin
                    state_d = S_IDLE;
                    stage_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                stage_d = '0;
            end
        endcase

        // Abort overrides the whole transition, so no WB/flag pulse can escape.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            count_d = '0;
            stage_d = '0;
        end

        // Moore outputs are decoded from the next state and registered.
        busy_d    = (state_d != S_IDLE);
        load_en_d = (state_d == S_LOAD);
        flag_d    = (state_d == S_MAC) && (count_d == LAST_CNT);
        done_d    = (state_d == S_DONE);
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_en_d[i] = (state_d == S_WB) && (stage_d == 3'(i));
        end
    end

    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            count_reg_q <= '0;
            stage_q     <= '0;
            busy_q      <= 1'b0;
            load_en_q   <= 1'b0;
            flag_q      <= 1'b0;
            stage_en_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            count_reg_q <= count_reg_d;
            stage_q     <= stage_d;
            busy_q      <= busy_d;
            load_en_q   <= load_en_d;
            flag_q      <= flag_d;
            stage_en_q  <= stage_en_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.load_en   = load_en_q;
    assign bus.count     = count_q;
    assign bus.count_reg = count_reg_q;
    assign bus.flag      = flag_q;
    assign bus.stage_sel = stage_q;
    assign bus.stage_en  = stage_en_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: default instance (5 stages, 4 MAC cycles)
// and a reduced instance (3 stages, 2 MAC cycles), checked cycle by cycle.
module tb_fft_stage_sequencer;
    logic clk_MAC = 1'b0;
    logic rst     = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_MAC = ~clk_MAC;

    fft_stage_sequencer_if #(.NUM_STAGES(5), .CNT_W(3)) if0 ();
    fft_stage_sequencer_if #(.NUM_STAGES(3), .CNT_W(3)) if1 ();

    fft_stage_sequencer #(.NUM_STAGES(5), .MAC_CYCLES(4), .CNT_W(3)) dut0 (
        .clk_MAC (clk_MAC),
        .rst     (rst),
        .bus     (if0)
    );

    fft_stage_sequencer #(.NUM_STAGES(3), .MAC_CYCLES(2), .CNT_W(3)) dut1 (
        .clk_MAC (clk_MAC),
        .rst     (rst),
        .bus     (if1)
    );

    // Handshake bits only: busy, load_en, flag, done, stage_en.
    localparam logic [31:0] HS_MASK = 32'h00F0_00FF;

    function automatic logic [31:0] pk(logic b, logic l, logic f, logic d,
                                       int cnt, int cr, int ss, int se);
        return {8'd0, b, l, f, d, 4'(cnt), 4'(cr), 4'(ss), 8'(se)};
    endfunction

    function automatic logic [31:0] obs0();
        return pk(if0.busy, if0.load_en, if0.flag, if0.done, int'(if0.count),
                  int'(if0.count_reg), int'(if0.stage_sel), int'(if0.stage_en));
    endfunction

    function automatic logic [31:0] obs1();
        return pk(if1.busy, if1.load_en, if1.flag, if1.done, int'(if1.count),
                  int'(if1.count_reg), int'(if1.stage_sel), int'(if1.stage_en));
    endfunction

    // MAC count shown r cycles after start was sampled (0 outside MAC).
    function automatic int exp_cnt(int r, int ns, int mc);
        int last;
        last = 1 + ns * (mc + 1);
        if (r >= 2 && r <= last && ((r - 2) % (mc + 1)) < mc) return (r - 2) % (mc + 1);
        return 0;
    endfunction

    // Expected output vector r cycles after start was sampled (r=0: idle).
    function automatic logic [31:0] expv(int r, int ns, int mc);
        int last, k, p, ss, se;
        logic b, l, f, d;
        last = 1 + ns * (mc + 1);
        b = (r >= 1); l = (r == 1); f = 1'b0; d = 1'b0; ss = 0; se = 0;
        if (r >= 2 && r <= last) begin
            k  = r - 2;
            ss = k / (mc + 1);
            p  = k % (mc + 1);
            f  = (p == mc - 1);
            if (p == mc) se = 1 << ss;
        end else if (r > last) begin
            d  = 1'b1;
            ss = ns - 1;
        end
        return pk(b, l, f, d, exp_cnt(r, ns, mc), (r >= 1) ? exp_cnt(r - 1, ns, mc) : 0, ss, se);
    endfunction

    task automatic tick();
        @(posedge clk_MAC);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expected);
        n_checks++;
        assert (obs === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expected);
        end
    endtask

    // Start pulse now, then check every cycle through first done; optional stray starts.
    task automatic run0(int extra_a, int extra_b, string tag);
        if0.start = 1'b1;
        for (int r = 1; r <= 27; r++) begin
            tick();
            chk($sformatf("%s_r%0d", tag, r), obs0(), expv(r, 5, 4));
            if0.start = (r == extra_a || r == extra_b);
        end
        if0.start = 1'b0;
    endtask

    initial begin
        if0.start = 1'b0; if0.abort = 1'b0; if0.ack = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0; if1.ack = 1'b0;

        // 1: reset held with start toggling, then released
        for (int i = 0; i < 4; i++) begin
            if0.start = i[0];
            tick();
            chk("reset_hold", obs0(), 32'd0);
        end
        if0.start = 1'b0;
        rst = 1'b1;
        tick();
        chk("reset_release", obs0(), 32'd0);
        tick();
        chk("reset_idle", obs0(), 32'd0);

        // abort with start in IDLE stays idle
        if0.start = 1'b1; if0.abort = 1'b1;
        tick();
        if0.start = 1'b0; if0.abort = 1'b0;
        chk("abort_start_idle", obs0(), 32'd0);

        // 2: single run, then ack
        run0(-1, -1, "run");
        if0.ack = 1'b1;
        tick();
        if0.ack = 1'b0;
        chk("ack_idle", obs0() & HS_MASK, 32'd0);

        // 3: stray starts at cycles 3 and 15 are ignored
        run0(3, 15, "busy_start");

        // 5: done held without ack, then ack+start together
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("done_hold_%0d", i), obs0(), expv(27 + i, 5, 4));
        end
        if0.ack = 1'b1; if0.start = 1'b1;
        tick();
        if0.ack = 1'b0; if0.start = 1'b0;
        chk("ack_start_idle", obs0() & HS_MASK, 32'd0);
        tick();
        chk("ack_start_norun", obs0() & HS_MASK, 32'd0);

        // 4: abort at stage_sel=2, count=1 (r=13)
        if0.start = 1'b1;
        for (int r = 1; r <= 13; r++) begin
            tick();
            if0.start = 1'b0;
            chk($sformatf("pre_abort_r%0d", r), obs0(), expv(r, 5, 4));
        end
        if0.abort = 1'b1;
        tick();
        if0.abort = 1'b0;
        chk("abort_next", obs0(), pk(0, 0, 0, 0, 0, 1, 0, 0));
        tick();
        chk("abort_settle", obs0(), 32'd0);
        run0(-1, -1, "after_abort");
        if0.ack = 1'b1;
        tick();
        if0.ack = 1'b0;
        chk("after_abort_ack", obs0() & HS_MASK, 32'd0);

        // async reset mid-run loses the run
        if0.start = 1'b1;
        for (int r = 1; r <= 8; r++) begin
            tick();
            if0.start = 1'b0;
        end
        chk("pre_rst_mid", obs0(), expv(8, 5, 4));
        #2 rst = 1'b0;
        #1 chk("rst_mid_async", obs0(), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_release", obs0(), 32'd0);

        // 6: reduced instance, 3 stages x 2 MAC cycles, done at 11
        if1.start = 1'b1;
        for (int r = 1; r <= 13; r++) begin
            tick();
            if1.start = 1'b0;
            chk($sformatf("small_r%0d", r), obs1(), expv(r, 3, 2));
        end
        if1.ack = 1'b1;
        tick();
        if1.ack = 1'b0;
        chk("small_ack", obs1() & HS_MASK, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
